// File: rtl/ext_pkg.sv
// Shared constants and types for the operand extender.
package ext_pkg;

  // Extension modes, sampled together with the operand.
  typedef enum logic [1:0] {
    ZEXT     = 2'b00,
    SEXT     = 2'b01,
    SEXT_SHL = 2'b10,
    RSVD     = 2'b11
  } ext_mode_e;

  // Occupancy of the two-entry result FIFO.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/operand_extender_fifo.sv
// Two-entry FIFO. The caller only asserts push when not_full and pop when
// not_empty. Slot 0 is always the oldest entry.
module operand_extender_fifo
  import ext_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         not_full
);

  fifo_state_e  state_q;
  fifo_state_e  state_d;
  logic [W-1:0] slot0;
  logic [W-1:0] slot1;

  // State register; reset empties the FIFO immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy: push adds one, pop removes one, both together hold.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_TWO;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_TWO:   if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Storage update: new data lands behind the oldest entry, or at the head
  // when the head is leaving or the FIFO is empty.
  // NOTE: storage is not reset; stale contents are never visible because head is gated by occupancy.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_EMPTY: if (push) slot0 <= push_data;
      ST_ONE: begin
        if (push && pop) slot0 <= push_data;
        else if (push)   slot1 <= push_data;
      end
      ST_TWO:   if (pop) slot0 <= slot1;
      default: ;
    endcase
  end

  assign not_empty = (state_q != ST_EMPTY);
  assign not_full  = (state_q != ST_TWO);
  assign head      = not_empty ? slot0 : '0;

endmodule

// File: rtl/operand_extender.sv
// Operand extender: zero/sign extension with optional left shift, computed
// at acceptance and buffered in a two-entry FIFO with valid/ready on both sides.
module operand_extender
  import ext_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  IN,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT,
  output logic             ERR
);

  generate
    if (IN_W >= OUT_W) begin : g_bad_width
      $error("operand_extender: IN_W must be smaller than OUT_W");
    end
    if (SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_shift
      $error("operand_extender: SHIFT must lie in 0..OUT_W-1");
    end
  endgenerate

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_out;
  logic             ext_err;
  logic             push;
  logic             pop;

  assign sext = {{(OUT_W-IN_W){IN[IN_W-1]}}, IN};

  // Extension of the offered operand; reserved mode yields zero with ERR set.
  always_comb begin
    ext_out = '0;
    ext_err = 1'b0;
    case (ext_mode_e'(MODE))
      ZEXT:     ext_out = {{(OUT_W-IN_W){1'b0}}, IN};
      SEXT:     ext_out = sext;
      SEXT_SHL: ext_out = sext << SHIFT;
      RSVD:     ext_err = 1'b1;
      default:  ext_err = 1'b1;
    endcase
  end

  assign push = IN_VALID && IN_READY;
  assign pop  = OUT_READY && OUT_VALID;

  operand_extender_fifo #(
    .W(OUT_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .push_data ({ext_err, ext_out}),
    .pop       (pop),
    .head      ({ERR, OUT}),
    .not_empty (OUT_VALID),
    .not_full  (IN_READY)
  );

endmodule

// File: tb/tb_operand_extender.sv
// Self-checking bench for operand_extender: directed mode vectors,
// backpressure, back-to-back throughput, async reset and random stalls.
module tb_operand_extender;

  localparam int IN_W  = 9;
  localparam int OUT_W = 16;
  localparam int SHIFT = 1;

  logic             clk       = 1'b0;
  logic             rst_b     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data   = '0;
  logic [1:0]       mode      = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IN_W-1:0]  in;
    logic [1:0]       mode;
    logic [OUT_W-1:0] out;
    logic             err;
  } vec_t;

  always #5 clk = ~clk;

  operand_extender #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .IN       (in_data),
    .MODE     (mode),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .OUT      (out_data),
    .ERR      (err)
  );

  // Reference: treat the operand as an integer, apply the mode arithmetically,
  // then reduce modulo 2**OUT_W. Returns {err, out}.
  function automatic logic [OUT_W:0] ref_model(input logic [IN_W-1:0] v, input logic [1:0] m);
    longint     val;
    longint     res;
    logic [63:0] bits;
    if (m == 2'b11) return {1'b1, {OUT_W{1'b0}}};
    val = longint'(v);
    if (m != 2'b00 && val >= (longint'(1) << (IN_W - 1))) val = val - (longint'(1) << IN_W);
    if (m == 2'b10) val = val * (longint'(1) << SHIFT);
    res = val % (longint'(1) << OUT_W);
    if (res < 0) res = res + (longint'(1) << OUT_W);
    bits = 64'(res);
    return {1'b0, bits[OUT_W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out: got %h expected 0000", out_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    @(negedge clk);
    rst_b = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_modes();
    vec_t vecs[8];
    vecs[0] = '{9'h166, 2'b01, 16'hFF66, 1'b0};
    vecs[1] = '{9'h166, 2'b00, 16'h0166, 1'b0};
    vecs[2] = '{9'h166, 2'b10, 16'hFECC, 1'b0};
    vecs[3] = '{9'h100, 2'b01, 16'hFF00, 1'b0};
    vecs[4] = '{9'h0FF, 2'b01, 16'h00FF, 1'b0};
    vecs[5] = '{9'h1FF, 2'b10, 16'hFFFE, 1'b0};
    vecs[6] = '{9'h1AB, 2'b11, 16'h0000, 1'b1};
    vecs[7] = '{9'h001, 2'b01, 16'h0001, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].in;
      mode     = vecs[i].mode;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mode_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_data !== vecs[i].out || err !== vecs[i].err) begin
        errors++; $display("FAIL mode_out[%0d]: got %h/%b expected %h/%b", i, out_data, err, vecs[i].out, vecs[i].err);
      end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode_drain[%0d]: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    mode      = 2'b01;
    in_valid  = 1'b1;
    in_data   = 9'h001;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0001 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first: got valid=%b out=%h ready=%b expected 1/0001/1", out_valid, out_data, in_ready);
    end
    in_data = 9'h002;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    in_data = 9'h003;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (in_ready !== 1'b0 || out_data !== 16'h0001 || err !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got ready=%b out=%h err=%b expected 0/0001/0", i, in_ready, out_data, err);
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 16'h0002 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second: got out=%h ready=%b expected 0002/1", out_data, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0003) begin
      errors++; $display("FAIL bp_third: got valid=%b out=%h expected 1/0003", out_valid, out_data);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [OUT_W:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'($urandom);
      mode     = 2'($urandom_range(0, 2));
      exp      = ref_model(in_data, mode);
      step();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || {err, out_data} !== exp) begin
        errors++; $display("FAIL b2b[%0d]: got valid=%b ready=%b res=%h expected 1/1/%h", i, out_valid, in_ready, {err, out_data}, exp);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'b11;
    in_data   = 9'h1AB;
    step();
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || err !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ar_full: got valid=%b err=%b ready=%b expected 1/1/0", out_valid, err, in_ready);
    end
    #3 rst_b = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL ar_immediate: got valid=%b ready=%b out=%h err=%b expected 0/1/0000/0", out_valid, in_ready, out_data, err);
    end
    #2 rst_b = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale: got %b expected 0", out_valid); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mode      = 2'b01;
    in_data   = 9'h0FF;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00FF || err !== 1'b0) begin
      errors++; $display("FAIL ar_first: got valid=%b out=%h err=%b expected 1/00FF/0", out_valid, out_data, err);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic [OUT_W:0] exp_q[$];
    int sent   = 0;
    int recv   = 0;
    int cycles = 0;
    bit pushed;
    bit popped;
    while ((sent < 1000 || exp_q.size() > 0) && cycles < 20000) begin
      checks++; if (out_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", cycles, out_valid, exp_q.size() > 0);
      end
      checks++; if (in_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL rnd_ready @%0d: got %b expected %b", cycles, in_ready, exp_q.size() < 2);
      end
      if (exp_q.size() > 0) begin
        checks++; if ({err, out_data} !== exp_q[0]) begin
          errors++; $display("FAIL rnd_data @%0d: got %h expected %h", cycles, {err, out_data}, exp_q[0]);
        end
      end
      in_valid  = (sent < 1000) && ($urandom_range(0, 99) < 70);
      in_data   = IN_W'($urandom);
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 99) < 65);
      pushed    = in_valid && (exp_q.size() < 2);
      popped    = out_ready && (exp_q.size() > 0);
      step();
      if (popped) begin
        void'(exp_q.pop_front());
        recv++;
      end
      if (pushed) begin
        exp_q.push_back(ref_model(in_data, mode));
        sent++;
      end
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (cycles >= 20000 || recv != 1000) begin
      errors++; $display("FAIL rnd_complete: got %0d results in %0d cycles expected 1000", recv, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_extender.md
OPERAND_EXTENDER -- requirements
Module: operand_extender

Interface
REQ-001 The block SHALL have parameter IN_W, default 9, meaning input operand width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning output operand width in bits; IN_W < OUT_W SHALL hold (elaboration error otherwise).
REQ-003 The block SHALL have parameter SHIFT, default 1, meaning the left-shift amount applied in mode SEXT_SHL; 0 <= SHIFT < OUT_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_b  input  1  reset, asynchronous, active-low.
REQ-006 IN_VALID  input  1  producer offers IN/MODE this cycle.
REQ-007 IN_READY  output  1  block can accept an operand this cycle.
REQ-008 IN  input  IN_W  raw operand.
REQ-009 MODE  input  2  extension mode, sampled with IN.
REQ-010 OUT_VALID  output  1  OUT/ERR hold a valid result.
REQ-011 OUT_READY  input  1  consumer takes the result this cycle.
REQ-012 OUT  output  OUT_W  extended result.
REQ-013 ERR  output  1  result was produced from a reserved MODE.

Function
REQ-014 A transfer on either side SHALL occur only in a cycle where VALID and READY are both high at the rising edge.
REQ-015 MODE 00 (ZEXT): OUT SHALL be IN with bits [OUT_W-1:IN_W] = 0.
REQ-016 MODE 01 (SEXT): OUT SHALL be IN with bits [OUT_W-1:IN_W] = IN[IN_W-1].
REQ-017 MODE 10 (SEXT_SHL): OUT SHALL be the SEXT result shifted left by SHIFT, zero-filled at LSBs, bits shifted above OUT_W-1 discarded.
REQ-018 MODE 11 (reserved): OUT SHALL be 0 and ERR SHALL be 1; for all other modes ERR SHALL be 0.
REQ-019 Extension SHALL be computed at acceptance and the result stored in a 2-entry FIFO; latency from accepting edge to OUT_VALID high SHALL be 1 cycle.
REQ-020 FIFO state SHALL be EMPTY, ONE or TWO; push only -> count+1, pop only -> count-1, push and pop together -> count unchanged.
REQ-021 IN_READY SHALL be a registered function of state: high in EMPTY and ONE, low in TWO (no combinational path from OUT_READY to IN_READY).
REQ-022 OUT_VALID SHALL be high exactly when state is not EMPTY; OUT/ERR SHALL present the oldest entry.
REQ-023 While OUT_VALID is high and OUT_READY is low, OUT and ERR SHALL remain stable.
REQ-024 Sustained throughput with OUT_READY held high SHALL be one operand per cycle with no bubbles.
REQ-025 Results SHALL leave in acceptance order; no operand SHALL be dropped or duplicated.
REQ-026 In state ONE with simultaneous push and pop, the new result SHALL appear on OUT the next cycle.
REQ-027 IN_VALID in state TWO SHALL be ignored (not accepted) until IN_READY returns high.

Reset
REQ-028 On rst_b low, state SHALL go to EMPTY immediately, regardless of clk.
REQ-029 During and after reset: OUT_VALID = 0, IN_READY = 1, OUT = 0, ERR = 0; stored entries SHALL be discarded.
REQ-030 Reset asserted mid-transfer SHALL lose in-flight entries without emitting a partial result; first accept after release behaves as from EMPTY.

Structure
REQ-031 Mode encodings ZEXT, SEXT, SEXT_SHL and RSVD SHALL be constants in shared package ext_pkg.
REQ-032 The 2-entry FIFO SHALL be sub-module operand_extender_fifo (parametrised by data width OUT_W+1); extension logic stays in operand_extender.

Verification (defaults IN_W=9, OUT_W=16, SHIFT=1)
REQ-033 IN=9'h166, MODE=01, OUT_READY=1 -> next cycle OUT=16'hFF66, ERR=0; MODE=00 -> 16'h0166; MODE=10 -> 16'hFECC.
REQ-034 IN=9'h100, MODE=01 -> 16'hFF00; IN=9'h0FF, MODE=01 -> 16'h00FF; IN=9'h1FF, MODE=10 -> 16'hFFFE.
REQ-035 OUT_READY=0; push 9'h001, 9'h002, 9'h003 back-to-back in SEXT -> IN_READY low after 2nd accept, 3rd not accepted, OUT holds 16'h0001; raise OUT_READY -> 0001, 0002, 0003 in order.
REQ-036 MODE=11, IN=9'h1AB -> OUT=16'h0000, ERR=1; following MODE=01, IN=9'h001 -> OUT=16'h0001, ERR=0.
REQ-037 Two entries stored, pulse rst_b low between clock edges -> OUT_VALID=0, IN_READY=1, OUT=0 immediately; no stale result after release.
REQ-038 Random VALID/READY stalls, 1000 operands, all modes -> output sequence matches reference model exactly.
